at86rf215_iq_unpack_axis: RTL
=============================

// Module: at86rf215_iq_unpack_axis
// PURPOSE
//  Stage directly downstream of the LVDS IQ word aligner. Takes aligned 32-bit
//  I/Q words plus write strobe and lock flag, checks the embedded sync bits,
//  extracts the 13-bit I and Q samples and sign-extends them to 16 bits.
//  Buffers samples in a FIFO and presents them as AXI4-Stream packets of
//  PACKET_LEN samples to the DMA path.
// PARAMETERS
//  FIFO_DEPTH      16  sample FIFO entries; power of two, >= 4
//  PACKET_LEN      256 samples per AXIS packet; >= 2
//  ERR_CNT_WIDTH   16  width of the saturating error/overflow counters
// PORTS
//  aclk             in   1   clock, shared with the aligner
//  aresetn          in   1   reset, asynchronous, active-low
//  enable           in   1   1 = accept samples; 0 = drop input, FIFO drains
//  synced_data      in   32  aligned word {2'b10,I[12:0],ic,2'b01,Q[12:0],qc}
//  write_en         in   1   synced_data valid this cycle
//  in_sync          in   1   aligner locked
//  m00_axis_tdata   out  32  {Q[15:0],I[15:0]}, each sign-extended from bit 12
//  m00_axis_tvalid  out  1   AXIS valid
//  m00_axis_tready  in   1   AXIS ready
//  m00_axis_tlast   out  1   last sample of packet
//  m00_axis_tuser   out  2   {qc,ic} control bits of the sample
//  overflow         out  1   sticky: a valid sample was dropped on FIFO full
//  overflow_count   out  ERR_CNT_WIDTH  dropped samples, saturating
//  frame_err_count  out  ERR_CNT_WIDTH  words with bad sync bits, saturating
//  clear_status     in   1   synchronous clear of overflow and both counters
// BEHAVIOUR
//  - Reset: tvalid/tlast/tdata/tuser=0, FIFO empty, packet count 0,
//    overflow=0, both counters 0. Asserting aresetn low mid-packet drops
//    tvalid immediately; the partial packet is discarded, not closed.
//  - Valid sample: enable & write_en & in_sync & synced_data[31:30]==2'b10 &
//    synced_data[15:14]==2'b01.
//  - Frame error: enable & write_en & in_sync with either sync field wrong.
//    Increment frame_err_count; the word is discarded. Words with
//    in_sync=0 are ignored silently.
//  - Field map: I=synced_data[29:17], ic=[16], Q=[13:1], qc=[0].
//    Sign-extend: I16={{3{I[12]}},I}. Pure wiring.
//  - Packet counter pcnt (0..PACKET_LEN-1) advances on every valid sample,
//    including dropped ones, so packet boundaries stay aligned to time.
//    tlast is stored with the sample when pcnt==PACKET_LEN-1, then pcnt
//    wraps to 0. in_sync falling or enable low resets pcnt to 0; the open
//    packet is left unterminated.
//  - FIFO write: a valid sample is written at edge k when not full, or when
//    full and a pop happens at the same edge. Otherwise it is dropped: set
//    overflow and increment overflow_count.
//  - Latency: a sample written at edge k into an empty FIFO gives
//    tvalid=1 with that data after edge k (1 cycle from input presentation).
//  - AXIS: tdata/tlast/tuser stay stable while tvalid & !tready. Pop on
//    tvalid & tready. tvalid never depends combinationally on tready.
//    Back-to-back beats sustain 1 sample/clk.
//  - Counters saturate at all-ones and never wrap. If clear_status and an
//    increment occur together, clear wins.
//  - enable low: no writes; queued samples keep draining on the AXIS port.
// TESTING
//  1. Reset, in_sync=1, write_en pulse with word 32'h8000_4000 (I=0,Q=0)
//     -> one beat tdata=0, tuser=0, tvalid high the cycle after the strobe.
//  2. Word with I=13'h1FFF, Q=13'h1000, ic=1, qc=0
//     -> tdata=32'hF000_FFFF, tuser=2'b01.
//  3. PACKET_LEN=4, 10 valid samples, tready=1 -> tlast on beats 4 and 8
//     only; beats 9 and 10 stay open.
//  4. tready=0, FIFO_DEPTH+3 valid samples -> FIFO holds the first
//     FIFO_DEPTH, overflow=1, overflow_count=3; release tready -> the
//     first FIFO_DEPTH samples come out in order; tlast stays at the
//     time-aligned positions.
//  5. write_en with synced_data[31:30]=2'b11, in_sync=1 -> no beat,
//     frame_err_count=1; same word with in_sync=0 -> count unchanged.
//  6. Full FIFO, tready=1 with a valid input at the same edge -> no drop,
//     occupancy unchanged; aresetn pulsed low mid-packet -> tvalid=0
//     immediately, counters=0, next packet starts at pcnt=0.

Source files
------------

// File: rtl/at86rf215_iq_unpack_axis.sv
// AT86RF215 I/Q unpacker: checks sync bits, sign-extends 13-bit I/Q samples,
// buffers them and emits time-aligned AXI4-Stream packets.
module at86rf215_iq_unpack_axis #(
    parameter int FIFO_DEPTH    = 16,
    parameter int PACKET_LEN    = 256,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     enable,
    input  logic [31:0]              synced_data,
    input  logic                     write_en,
    input  logic                     in_sync,
    output logic [31:0]              m00_axis_tdata,
    output logic                     m00_axis_tvalid,
    input  logic                     m00_axis_tready,
    output logic                     m00_axis_tlast,
    output logic [1:0]               m00_axis_tuser,
    output logic                     overflow,
    output logic [ERR_CNT_WIDTH-1:0] overflow_count,
    output logic [ERR_CNT_WIDTH-1:0] frame_err_count,
    input  logic                     clear_status
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(PACKET_LEN);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PLAST_C = PW'(PACKET_LEN - 1);

    logic          w_acc;
    logic          w_sync_ok;
    logic          w_valid;
    logic          w_ferr;
    logic [15:0]   w_i16;
    logic [15:0]   w_q16;
    logic          w_last;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [34:0]   w_head;

    logic [34:0]              r_mem [FIFO_DEPTH];
    logic [AW-1:0]            r_wptr;
    logic [AW-1:0]            r_rptr;
    logic [AW:0]              r_count;
    logic [PW-1:0]            r_pcnt;
    logic                     r_ovf;
    logic [ERR_CNT_WIDTH-1:0] r_ovf_cnt;
    logic [ERR_CNT_WIDTH-1:0] r_fe_cnt;

    assign w_acc     = enable & write_en & in_sync;
    assign w_sync_ok = (synced_data[31:30] == 2'b10) &&
                       (synced_data[15:14] == 2'b01);
    assign w_valid   = w_acc & w_sync_ok;
    assign w_ferr    = w_acc & ~w_sync_ok;

    assign w_i16 = {{3{synced_data[29]}}, synced_data[29:17]};
    assign w_q16 = {{3{synced_data[13]}}, synced_data[13:1]};

    assign w_last  = (r_pcnt == PLAST_C);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = ~w_empty & m00_axis_tready;
    // A full FIFO still accepts a sample when a beat leaves on the same edge
    assign w_push  = w_valid & (~w_full | w_pop);
    assign w_drop  = w_valid & ~w_push;

    assign w_head          = r_mem[r_rptr];
    assign m00_axis_tvalid = ~w_empty;
    assign m00_axis_tdata  = w_empty ? 32'h0 : w_head[31:0];
    assign m00_axis_tlast  = w_empty ? 1'b0  : w_head[32];
    assign m00_axis_tuser  = w_empty ? 2'b00 : w_head[34:33];

    assign overflow        = r_ovf;
    assign overflow_count  = r_ovf_cnt;
    assign frame_err_count = r_fe_cnt;

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {synced_data[0], synced_data[16], w_last,
                              w_q16, w_i16};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Packet position follows time, so dropped samples still advance it
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pcnt <= '0;
        end else if (!enable || !in_sync) begin
            r_pcnt <= '0;
        end else if (w_valid) begin
            r_pcnt <= w_last ? '0 : r_pcnt + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ovf     <= 1'b0;
            r_ovf_cnt <= '0;
            r_fe_cnt  <= '0;
        end else if (clear_status) begin
            r_ovf     <= 1'b0;
            r_ovf_cnt <= '0;
            r_fe_cnt  <= '0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (!(&r_ovf_cnt)) begin
                    r_ovf_cnt <= r_ovf_cnt + 1'b1;
                end
            end
            if (w_ferr && !(&r_fe_cnt)) begin
                r_fe_cnt <= r_fe_cnt + 1'b1;
            end
        end
    end

endmodule
